mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with HI/LO registers, successor to the
//   single-cycle ALU path. Sits in the EX stage of the pipelined mips core beside the ALU;
//   the hazard unit stalls on busy. Supports signed/unsigned mult/div, MTHI/MTLO writes,
//   configurable latency and a flush for exception/cancel.
// PARAMETERS
//   WIDTH        32   operand / HI / LO width in bits
//   MULT_CYCLES  5    busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10   busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-low reset
//   start   in   1      issue op on this edge (qualified by busy=0, flush=0)
//   op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A       in   WIDTH  operand rs (dividend / multiplicand / MT source)
//   B       in   WIDTH  operand rt (divisor / multiplier)
//   flush   in   1      abort in-flight op, no HI/LO commit
//   busy    out  1      op in flight; EX stalls mult/div/mf*/mt* while high
//   hi      out  WIDTH  HI register (registered)
//   lo      out  WIDTH  LO register (registered)
// BEHAVIOUR
//   - Reset (reset=0, async): busy=0, hi=0, lo=0, counter=0, pending result cleared.
//     Reset mid-operation aborts; nothing committed after release.
//   - States: IDLE, RUN. IDLE->RUN on edge with start=1, busy=0, flush=0, op in 0..3.
//   - Operands latched at issue edge; A/B changes afterwards have no effect.
//   - Issue at edge k: busy=1 after edge k; counter loads N (MULT_CYCLES or DIV_CYCLES),
//     decrements each edge; at edge k+N hi/lo commit and busy=0 simultaneously.
//     busy is high exactly N cycles.
//   - MULT: {hi,lo} = signed A*B (2*WIDTH bits). MULTU: unsigned.
//   - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//     DIVU: unsigned quotient/remainder.
//   - Divide by zero (B=0): op runs full DIV_CYCLES, hi/lo left unchanged.
//   - Signed overflow (A=most-negative, B=-1): lo=A, hi=0.
//   - MTHI/MTLO with start=1, busy=0, flush=0: hi (resp. lo) <= A at that edge; busy stays 0.
//   - start while busy=1: ignored (any op, incl. MT*); in-flight op unaffected.
//   - flush=1: RUN->IDLE at next edge, busy=0, no commit; start on same edge ignored.
//     flush on commit edge (counter=1) also suppresses commit. flush in IDLE: no effect.
//   - op 6-7 with start=1: no state change.
//   - Commit edge with start=1: start ignored (busy still 1 that cycle); new op issues
//     only from a cycle where busy=0.
// TESTING
//   - MULT A=0xFFFFFFFE(-2), B=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
//     MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//   - DIV A=-7, B=2 -> busy 10 cycles, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1);
//     DIVU A=7, B=2 -> lo=3, hi=1.
//   - hi=0x11, lo=0x22; DIV A=5, B=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged;
//     DIV A=0x80000000, B=-1 -> lo=0x80000000, hi=0.
//   - MULT 4*5 issued, MTLO A=9 with start at cycle 2 of busy -> ignored, lo=20 at end;
//     MTHI A=0xAB in IDLE -> hi=0xAB next edge, busy never rises.
//   - DIV issued, flush at cycle 4 -> busy=0 next edge, hi/lo keep prior values;
//     flush on commit edge -> no commit.
//   - reset pulled low mid-MULT (cycle 3) -> busy, hi, lo =0 immediately, no commit after
//     release; rerun with MULT_CYCLES=1, DIV_CYCLES=1 -> busy exactly 1 cycle.

Source files
------------

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits
//   in the EX stage beside the ALU. A mult/div op holds busy high for a fixed
//   number of cycles and then commits {hi,lo}. MTHI/MTLO write the registers
//   directly in a single edge. flush aborts an in-flight op without committing.
//
// Parameters
//   WIDTH        operand / HI / LO width
//   MULT_CYCLES  busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>=1)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   issue op this edge (qualified by busy=0, flush=0)
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A      in   rs operand (dividend / multiplicand / MT source)
//   B      in   rt operand (divisor / multiplier)
//   flush  in   abort in-flight op, no HI/LO commit
//   busy   out  op in flight
//   hi     out  HI register
//   lo     out  LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    state_e             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Result of the latched op, presented to the registers on the commit edge.
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               commit_en_d;

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0] div_b, a_mag, b_mag, q_mag, r_mag;
    logic             a_neg, b_neg;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        hi_d        = hi_q;
        lo_d        = lo_q;
        commit_en_d = 1'b1;

        prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        // Signed divide via magnitudes: quotient truncates toward zero and the
        // remainder takes the dividend's sign. most-negative / -1 falls out as
        // quotient = most-negative, remainder = 0 through two's-complement wrap.
        div_b = (b_q == '0) ? WIDTH'(1) : b_q;
        a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
        b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
        a_mag = a_neg ? (WIDTH'(0) - a_q) : a_q;
        b_mag = b_neg ? (WIDTH'(0) - div_b) : div_b;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;

        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
                lo_d        = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
                hi_d        = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
                // Divide by zero still runs the full latency but leaves HI/LO alone.
                commit_en_d = (b_q != '0);
            end
            default: commit_en_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q <= S_RUN;
                                busy_q  <= 1'b1;
                                cnt_q   <= op[1] ? DIV_N : MULT_N;
                                op_q    <= op;
                                a_q     <= A;
                                b_q     <= B;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // start is ignored throughout RUN, including the commit edge.
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (commit_en_d) begin
                            hi_q <= hi_d;
                            lo_q <= lo_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit. One instance uses the default latencies
//   (5 / 10); a second instance with both latencies set to 1 checks the
//   single-cycle case. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO  = 3'd5, NOP = 3'd6;

    logic        clk;
    logic        reset;
    logic        start, start1;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        flush;
    logic        busy, busy1;
    logic [31:0] hi, lo, hi1, lo1;

    int vectors    = 0;
    int miscompares = 0;
    int n;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy1), .hi(hi1), .lo(lo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; leaves the bench one cycle after the issue edge.
    task automatic issue(input bit use1, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b;
        if (use1) start1 = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'hDEAD_BEEF;   // operands must already be latched
    endtask

    // Counts falling edges with busy high, bounded so a stuck busy cannot hang the run.
    task automatic wait_busy(input bit use1, output int cnt);
        cnt = 0;
        while ((use1 ? busy1 : busy) && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input bit use1, input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        issue(use1, o, a, b);
        wait_busy(use1, c);
        check({tag, " busy_cycles"}, 32'(c), 32'(cyc));
        check({tag, " hi"}, use1 ? hi1 : hi, exp_hi);
        check({tag, " lo"}, use1 ? lo1 : lo, exp_lo);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        op = o; A = a; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start1 = 1'b0; flush = 1'b0;
        op = 3'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(0, "mult", MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(0, "multu", MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op(0, "div", DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(0, "divu", DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);

        mt(MTHI, 32'h11);
        mt(MTLO, 32'h22);
        check("mt setup hi", hi, 32'h11);
        check("mt setup lo", lo, 32'h22);
        run_op(0, "div0", DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op(0, "divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // MTLO while busy (cycle 2) is ignored.
        issue(0, MULT, 32'd4, 32'd5);
        @(negedge clk);
        op = MTLO; A = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_busy(0, n);
        check("mult_mtlo busy_cycles", 32'(n + 2), 32'd5);
        check("mult_mtlo lo", lo, 32'd20);
        check("mult_mtlo hi", hi, 32'd0);

        // MTHI in IDLE: one edge, busy never rises.
        mt(MTHI, 32'hAB);
        check("mthi busy", {31'b0, busy}, 32'd0);
        check("mthi hi", hi, 32'hAB);
        @(negedge clk);
        check("mthi busy later", {31'b0, busy}, 32'd0);

        // Flush at cycle 4 of a DIV; a start on the same edge is also ignored.
        issue(0, DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        flush = 1'b1; op = MTHI; A = 32'h55; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush hi", hi, 32'hAB);
        check("flush lo", lo, 32'd20);
        @(negedge clk);
        check("flush no late commit", lo, 32'd20);

        // Flush on the commit edge (5th busy cycle of a MULTU).
        issue(0, MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_commit busy", {31'b0, busy}, 32'd0);
        check("flush_commit lo", lo, 32'd20);
        check("flush_commit hi", hi, 32'hAB);

        // start with MTHI on the commit edge is ignored; the DIVU result lands.
        issue(0, DIVU, 32'd9, 32'd4);
        repeat (9) @(negedge clk);
        op = MTHI; A = 32'h77; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("commit_start busy", {31'b0, busy}, 32'd0);
        check("commit_start hi", hi, 32'd1);
        check("commit_start lo", lo, 32'd2);

        // No-op opcode and flush in IDLE change nothing.
        mt(NOP, 32'h99);
        check("nop busy", {31'b0, busy}, 32'd0);
        check("nop hi", hi, 32'd1);
        flush = 1'b1;
        mt(MTLO, 32'h66);
        flush = 1'b0;
        check("idle flush lo", lo, 32'd2);

        // Asynchronous reset at cycle 3 of a MULT.
        issue(0, MULT, 32'd4, 32'd5);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid busy", {31'b0, busy}, 32'd0);
        check("rst_mid hi", hi, 32'd0);
        check("rst_mid lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_after busy", {31'b0, busy}, 32'd0);
        check("rst_after lo", lo, 32'd0);
        check("rst_after hi", hi, 32'd0);

        // Single-cycle latency instance.
        run_op(1, "lat1 mult", MULT, 32'd3, 32'd4, 1, 32'd0, 32'd12);
        run_op(1, "lat1 div", DIV, 32'hFFFF_FFF7, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
